// File: rtl/sys_rst_seq.sv
// rtl/sys_rst_seq.sv - staged active-low reset sequencer with input debounce, soft-reset hold and sticky cause
module sys_rst_seq #(
  parameter int N_OUT        = 4,
  parameter int SYNC_STAGES  = 2,
  parameter int DEBOUNCE_CYC = 1024,
  parameter int STAGE_DLY    = 16,
  parameter int SOFT_HOLD    = 64
) (
  input  logic             Clk,
  input  logic             sys_rst_n,
  input  logic             ext_rst_n,
  input  logic             pll_locked,
  input  logic             soft_rst_req,
  input  logic             cause_clr,
  output logic [N_OUT-1:0] rst_n_out,
  output logic [1:0]       seq_state,
  output logic [3:0]       rst_cause
);

  localparam int DW = $clog2(DEBOUNCE_CYC + 1);
  localparam int TW = $clog2(STAGE_DLY + 1);
  localparam int SW = $clog2(N_OUT + 1);
  localparam int HW = $clog2(SOFT_HOLD + 1);

  localparam logic [DW-1:0] DEB_MAX    = DW'(DEBOUNCE_CYC);
  localparam logic [TW-1:0] DLY_LAST   = TW'(STAGE_DLY - 1);
  localparam logic [SW-1:0] STAGE_LAST = SW'(N_OUT - 1);
  localparam logic [HW-1:0] SOFT_LAST  = HW'(SOFT_HOLD - 1);

  typedef enum logic [1:0] {
    ST_HOLD    = 2'd0,
    ST_RELEASE = 2'd1,
    ST_RUN     = 2'd2,
    ST_SOFT    = 2'd3
  } state_t;

  state_t                 state_q, state_d;
  logic [SYNC_STAGES-1:0] ext_sync_q, ext_sync_d;
  logic [SYNC_STAGES-1:0] lock_sync_q, lock_sync_d;
  logic [DW-1:0]          deb_cnt_q, deb_cnt_d;
  logic [TW-1:0]          dly_cnt_q, dly_cnt_d;
  logic [SW-1:0]          stage_q, stage_d;
  logic [HW-1:0]          soft_cnt_q, soft_cnt_d;
  logic [N_OUT-1:0]       rst_n_out_q, rst_n_out_d;
  logic [3:0]             cause_q, cause_d;

  logic ext_sync;
  logic lock_sync;
  logic ok;
  logic stage_done;
  logic last_release;

  assign ext_sync     = ext_sync_q[SYNC_STAGES-1];
  assign lock_sync    = lock_sync_q[SYNC_STAGES-1];
  assign ok           = ext_sync & lock_sync;
  assign stage_done   = (dly_cnt_q == DLY_LAST);
  assign last_release = stage_done && (stage_q == STAGE_LAST);

  always_ff @(posedge Clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      state_q     <= ST_HOLD;
      ext_sync_q  <= '0;
      lock_sync_q <= '0;
      deb_cnt_q   <= '0;
      dly_cnt_q   <= '0;
      stage_q     <= '0;
      soft_cnt_q  <= '0;
      rst_n_out_q <= '0;
      cause_q     <= 4'b1000;
    end else begin
      state_q     <= state_d;
      ext_sync_q  <= ext_sync_d;
      lock_sync_q <= lock_sync_d;
      deb_cnt_q   <= deb_cnt_d;
      dly_cnt_q   <= dly_cnt_d;
      stage_q     <= stage_d;
      soft_cnt_q  <= soft_cnt_d;
      rst_n_out_q <= rst_n_out_d;
      cause_q     <= cause_d;
    end
  end

  // Loss of ok always wins; a soft request only diverts to SOFT while the inputs are clean.
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_HOLD: begin
        if (ok && (deb_cnt_q == DEB_MAX) && !soft_rst_req) state_d = ST_RELEASE;
      end
      ST_RELEASE: begin
        if (!ok)               state_d = ST_HOLD;
        else if (soft_rst_req) state_d = ST_SOFT;
        else if (last_release) state_d = ST_RUN;
      end
      ST_RUN: begin
        if (!ok)               state_d = ST_HOLD;
        else if (soft_rst_req) state_d = ST_SOFT;
      end
      ST_SOFT: begin
        if (!ok)                          state_d = ST_HOLD;
        else if (soft_cnt_q == SOFT_LAST) state_d = ST_HOLD;
      end
      default: state_d = ST_HOLD;
    endcase
  end

  always_comb begin
    ext_sync_d  = {ext_sync_q[SYNC_STAGES-2:0], ext_rst_n};
    lock_sync_d = {lock_sync_q[SYNC_STAGES-2:0], pll_locked};

    deb_cnt_d = '0;
    if (state_q == ST_HOLD && ok) begin
      deb_cnt_d = (deb_cnt_q == DEB_MAX) ? deb_cnt_q : deb_cnt_q + DW'(1);
    end

    dly_cnt_d = '0;
    stage_d   = '0;
    if (state_q == ST_RELEASE && state_d == ST_RELEASE) begin
      if (stage_done) begin
        stage_d = stage_q + SW'(1);
      end else begin
        dly_cnt_d = dly_cnt_q + TW'(1);
        stage_d   = stage_q;
      end
    end

    soft_cnt_d = '0;
    if (state_q == ST_SOFT && state_d == ST_SOFT && soft_cnt_q != SOFT_LAST) begin
      soft_cnt_d = soft_cnt_q + HW'(1);
    end

    // Outputs only ever rise one at a time in RELEASE; every other path drops them together.
    rst_n_out_d = '0;
    if (state_d == ST_RUN) begin
      rst_n_out_d = '1;
    end else if (state_d == ST_RELEASE && state_q == ST_RELEASE) begin
      for (int i = 0; i < N_OUT; i++) begin
        rst_n_out_d[i] = rst_n_out_q[i] | (stage_done && (stage_q == SW'(i)));
      end
    end

    // Inputs are clean on entry to every non-HOLD state, so a low sync there is a falling edge.
    cause_d = (cause_clr ? 4'b0000 : cause_q) |
              {1'b0,
               soft_rst_req,
               (state_q != ST_HOLD) & ~lock_sync,
               (state_q != ST_HOLD) & ~ext_sync};
  end

  assign rst_n_out = rst_n_out_q;
  assign seq_state = state_q;
  assign rst_cause = cause_q;

endmodule

// File: tb/tb_sys_rst_seq.sv
// tb/tb_sys_rst_seq.sv - vector table, corner sequences and random run of sys_rst_seq against a timeline model
module tb_sys_rst_seq;

  localparam int N_OUT        = 3;
  localparam int SYNC_STAGES  = 2;
  localparam int DEBOUNCE_CYC = 8;
  localparam int STAGE_DLY    = 4;
  localparam int SOFT_HOLD    = 5;

  logic             Clk = 1'b0;
  logic             sys_rst_n = 1'b1;
  logic             ext_rst_n = 1'b1;
  logic             pll_locked = 1'b1;
  logic             soft_rst_req = 1'b0;
  logic             cause_clr = 1'b0;
  logic [N_OUT-1:0] rst_n_out;
  logic [1:0]       seq_state;
  logic [3:0]       rst_cause;

  int total = 0;
  int bad   = 0;

  always #5 Clk = ~Clk;

  sys_rst_seq #(
    .N_OUT       (N_OUT),
    .SYNC_STAGES (SYNC_STAGES),
    .DEBOUNCE_CYC(DEBOUNCE_CYC),
    .STAGE_DLY   (STAGE_DLY),
    .SOFT_HOLD   (SOFT_HOLD)
  ) dut (
    .Clk         (Clk),
    .sys_rst_n   (sys_rst_n),
    .ext_rst_n   (ext_rst_n),
    .pll_locked  (pll_locked),
    .soft_rst_req(soft_rst_req),
    .cause_clr   (cause_clr),
    .rst_n_out   (rst_n_out),
    .seq_state   (seq_state),
    .rst_cause   (rst_cause)
  );

  // Model: phase 0 HOLD, 1 RELEASE, 2 RUN, 3 SOFT; m_t counts edges since entering RELEASE/SOFT.
  int         m_phase;
  int         m_clean;
  int         m_t;
  logic [3:0] m_cause;
  logic       m_ext_pipe[$];
  logic       m_lock_pipe[$];

  task automatic model_reset();
    m_phase = 0;
    m_clean = 0;
    m_t     = 0;
    m_cause = 4'b1000;
    m_ext_pipe  = {};
    m_lock_pipe = {};
    for (int i = 0; i < SYNC_STAGES; i++) begin
      m_ext_pipe.push_back(1'b0);
      m_lock_pipe.push_back(1'b0);
    end
  endtask

  task automatic model_step(input logic e_in, input logic l_in, input logic s, input logic c);
    logic e, l, ok, nh;
    e  = m_ext_pipe[SYNC_STAGES-1];
    l  = m_lock_pipe[SYNC_STAGES-1];
    ok = e & l;
    nh = (m_phase != 0);
    m_cause = (c ? 4'b0000 : m_cause) | {1'b0, s, nh & ~l, nh & ~e};
    m_ext_pipe.push_front(e_in);
    void'(m_ext_pipe.pop_back());
    m_lock_pipe.push_front(l_in);
    void'(m_lock_pipe.pop_back());
    if (!ok && nh) begin
      m_phase = 0;
      m_clean = 0;
    end else begin
      case (m_phase)
        0: begin
          if (!ok) m_clean = 0;
          else if (m_clean == DEBOUNCE_CYC && !s) begin
            m_phase = 1;
            m_t     = 0;
          end else if (m_clean < DEBOUNCE_CYC) m_clean++;
        end
        1: begin
          if (s) begin
            m_phase = 3;
            m_t     = 0;
          end else begin
            m_t++;
            if (m_t == N_OUT * STAGE_DLY) m_phase = 2;
          end
        end
        2: begin
          if (s) begin
            m_phase = 3;
            m_t     = 0;
          end
        end
        default: begin
          m_t++;
          if (m_t == SOFT_HOLD) begin
            m_phase = 0;
            m_clean = 0;
          end
        end
      endcase
    end
  endtask

  function automatic logic [N_OUT-1:0] model_out();
    logic [N_OUT-1:0] o;
    for (int i = 0; i < N_OUT; i++) begin
      o[i] = (m_phase == 2) || (m_phase == 1 && m_t >= (i + 1) * STAGE_DLY);
    end
    return o;
  endfunction

  task automatic check(input string name, input logic [N_OUT-1:0] eo, input logic [1:0] es,
                       input logic [3:0] ec);
    total++;
    if (rst_n_out !== eo || seq_state !== es || rst_cause !== ec) begin
      bad++;
      $display("FAIL %s: got out=%b state=%0d cause=%b, want out=%b state=%0d cause=%b",
               name, rst_n_out, seq_state, rst_cause, eo, es, ec);
    end
  endtask

  // Entered at a negedge: drive, let one posedge happen, compare at the following negedge.
  task automatic cycle(input logic e, input logic l, input logic s, input logic c);
    ext_rst_n    = e;
    pll_locked   = l;
    soft_rst_req = s;
    cause_clr    = c;
    @(posedge Clk);
    model_step(e, l, s, c);
    @(negedge Clk);
    check("model", model_out(), 2'(m_phase), m_cause);
  endtask

  task automatic do_reset();
    sys_rst_n = 1'b0;
    #1;
    check("async_reset", '0, 2'd0, 4'b1000);
    model_reset();
    @(negedge Clk);
    @(negedge Clk);
    sys_rst_n = 1'b1;
  endtask

  typedef struct {
    int         n;
    logic       e;
    logic       l;
    logic       s;
    logic       c;
    logic [2:0] out;
    logic [1:0] st;
    logic [3:0] cause;
  } vec_t;

  vec_t tbl[$];

  initial begin
    tbl.push_back('{10, 1'b1, 1'b1, 1'b0, 1'b0, 3'b000, 2'd0, 4'b1000});
    tbl.push_back('{ 1, 1'b1, 1'b1, 1'b0, 1'b0, 3'b000, 2'd1, 4'b1000});
    tbl.push_back('{ 3, 1'b1, 1'b1, 1'b0, 1'b0, 3'b000, 2'd1, 4'b1000});
    tbl.push_back('{ 1, 1'b1, 1'b1, 1'b0, 1'b0, 3'b001, 2'd1, 4'b1000});
    tbl.push_back('{ 4, 1'b1, 1'b1, 1'b0, 1'b0, 3'b011, 2'd1, 4'b1000});
    tbl.push_back('{ 3, 1'b1, 1'b1, 1'b0, 1'b0, 3'b011, 2'd1, 4'b1000});
    tbl.push_back('{ 1, 1'b1, 1'b1, 1'b0, 1'b0, 3'b111, 2'd2, 4'b1000});
    tbl.push_back('{ 3, 1'b1, 1'b1, 1'b0, 1'b0, 3'b111, 2'd2, 4'b1000});
    tbl.push_back('{ 1, 1'b1, 1'b1, 1'b1, 1'b0, 3'b000, 2'd3, 4'b1100});
    tbl.push_back('{ 4, 1'b1, 1'b1, 1'b0, 1'b0, 3'b000, 2'd3, 4'b1100});
    tbl.push_back('{ 1, 1'b1, 1'b1, 1'b0, 1'b0, 3'b000, 2'd0, 4'b1100});
    tbl.push_back('{ 8, 1'b1, 1'b1, 1'b0, 1'b0, 3'b000, 2'd0, 4'b1100});
    tbl.push_back('{ 1, 1'b1, 1'b1, 1'b0, 1'b0, 3'b000, 2'd1, 4'b1100});
    tbl.push_back('{11, 1'b1, 1'b1, 1'b0, 1'b0, 3'b011, 2'd1, 4'b1100});
    tbl.push_back('{ 1, 1'b1, 1'b1, 1'b0, 1'b0, 3'b111, 2'd2, 4'b1100});
    tbl.push_back('{ 2, 1'b1, 1'b0, 1'b0, 1'b0, 3'b111, 2'd2, 4'b1100});
    tbl.push_back('{ 1, 1'b1, 1'b0, 1'b0, 1'b1, 3'b000, 2'd0, 4'b0010});
    tbl.push_back('{10, 1'b1, 1'b1, 1'b0, 1'b0, 3'b000, 2'd0, 4'b0010});
    tbl.push_back('{12, 1'b1, 1'b1, 1'b0, 1'b0, 3'b011, 2'd1, 4'b0010});
    tbl.push_back('{ 1, 1'b1, 1'b1, 1'b0, 1'b0, 3'b111, 2'd2, 4'b0010});
    tbl.push_back('{ 1, 1'b1, 1'b1, 1'b0, 1'b1, 3'b111, 2'd2, 4'b0000});

    #2;
    do_reset();
    foreach (tbl[k]) begin
      for (int j = 0; j < tbl[k].n; j++) cycle(tbl[k].e, tbl[k].l, tbl[k].s, tbl[k].c);
      check($sformatf("vec%0d", k), tbl[k].out, tbl[k].st, tbl[k].cause);
    end

    // One-cycle lock drop at edge 6 restarts the debounce count.
    do_reset();
    for (int j = 0; j < 6; j++) cycle(1'b1, 1'b1, 1'b0, 1'b0);
    cycle(1'b1, 1'b0, 1'b0, 1'b0);
    for (int j = 0; j < 10; j++) cycle(1'b1, 1'b1, 1'b0, 1'b0);
    check("bounce_hold", 3'b000, 2'd0, 4'b1000);
    cycle(1'b1, 1'b1, 1'b0, 1'b0);
    check("bounce_release", 3'b000, 2'd1, 4'b1000);

    // External reset after the first output has released.
    do_reset();
    for (int j = 0; j < 15; j++) cycle(1'b1, 1'b1, 1'b0, 1'b0);
    check("mid_rel_first", 3'b001, 2'd1, 4'b1000);
    for (int j = 0; j < 2; j++) cycle(1'b0, 1'b1, 1'b0, 1'b0);
    check("mid_rel_sync_lag", 3'b001, 2'd1, 4'b1000);
    cycle(1'b0, 1'b1, 1'b0, 1'b0);
    check("mid_rel_fault", 3'b000, 2'd0, 4'b1001);
    for (int j = 0; j < 10; j++) cycle(1'b1, 1'b1, 1'b0, 1'b0);
    check("mid_rel_rehold", 3'b000, 2'd0, 4'b1001);
    for (int j = 0; j < 4; j++) cycle(1'b1, 1'b1, 1'b0, 1'b0);
    check("mid_rel_rerelease", 3'b000, 2'd1, 4'b1001);
    cycle(1'b1, 1'b1, 1'b0, 1'b0);
    check("mid_rel_idx0", 3'b001, 2'd1, 4'b1001);

    // Power-on reset asserted mid-RELEASE takes effect without a clock edge.
    do_reset();

    for (int j = 0; j < 6000; j++) begin
      if (j % 1500 == 1499) do_reset();
      cycle(logic'($urandom_range(0, 79) != 0), logic'($urandom_range(0, 79) != 0),
            logic'($urandom_range(0, 149) == 0), logic'($urandom_range(0, 39) == 0));
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
